// File: rtl/keypad_emulator.sv
// keypad_emulator: plays the keypad side of a 4x4 column-scan keypad. Queued key
// commands are each held for HOLD_CYCLES and then released for GAP_CYCLES.
// Build option: define KEYPAD_EMU_FIFO_EN for a FIFO_DEPTH-entry command queue
// (default build uses a single-entry command buffer).
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 500000,
  parameter int unsigned GAP_CYCLES  = 500000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  output logic       key_active,
  output logic       key_done,
  output logic       busy
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("keypad_emulator: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key;
  logic             r_key_active;
  logic             r_key_done;
  logic [3:0]       r_row_n;

  logic             w_q_empty;
  logic [3:0]       w_q_head;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_pos;
  logic [3:0]       w_row_drv;

  // Key code -> {row[1:0], col[1:0]} in the physical keypad layout.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    logic [3:0] pos;
    case (key)
      4'h1:    pos = {2'd0, 2'd0};
      4'h2:    pos = {2'd0, 2'd1};
      4'h3:    pos = {2'd0, 2'd2};
      4'hA:    pos = {2'd0, 2'd3};
      4'h4:    pos = {2'd1, 2'd0};
      4'h5:    pos = {2'd1, 2'd1};
      4'h6:    pos = {2'd1, 2'd2};
      4'hB:    pos = {2'd1, 2'd3};
      4'h7:    pos = {2'd2, 2'd0};
      4'h8:    pos = {2'd2, 2'd1};
      4'h9:    pos = {2'd2, 2'd2};
      4'hC:    pos = {2'd2, 2'd3};
      4'h0:    pos = {2'd3, 2'd0};
      4'hF:    pos = {2'd3, 2'd1};
      4'hE:    pos = {2'd3, 2'd2};
      default: pos = {2'd3, 2'd3};
    endcase
    return pos;
  endfunction

  assign w_push = cmd_valid && cmd_ready;
  assign w_pop  = (r_state == ST_IDLE) && !w_q_empty;

`ifdef KEYPAD_EMU_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Command queue: power-of-two depth, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd_key;
  end

  assign cmd_ready = (r_count != CW'(FIFO_DEPTH));
  assign w_q_empty = (r_count == '0);
  assign w_q_head  = r_mem[r_rd_ptr];
`else
  logic       r_buf_vld;
  logic [3:0] r_buf_key;

  // Single-entry buffer: refilled only once the FSM has taken the previous key.
  always_ff @(posedge clk) begin
    if (rst)         r_buf_vld <= 1'b0;
    else if (w_push) r_buf_vld <= 1'b1;
    else if (w_pop)  r_buf_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf_key <= cmd_key;
  end

  assign cmd_ready = !r_buf_vld;
  assign w_q_empty = !r_buf_vld;
  assign w_q_head  = r_buf_key;
`endif

  always_ff @(posedge clk) begin
    if (w_pop) r_key <= w_q_head;
  end

  // Press/release sequencer; key_done is raised for the final GAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_key_active <= 1'b0;
      r_key_done   <= 1'b0;
    end else begin
      r_key_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_q_empty) begin
            r_state      <= ST_PRESS;
            r_cnt        <= HOLD_LD;
            r_key_active <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (r_cnt == '0) begin
            r_state      <= ST_GAP;
            r_cnt        <= GAP_LD;
            r_key_active <= 1'b0;
            r_key_done   <= (GAP_CYCLES == 1);
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt      <= r_cnt - CNT_ONE;
            r_key_done <= (r_cnt == CNT_ONE);
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_key_active <= 1'b0;
        end
      endcase
    end
  end

  // Only the latched key's row follows its column strobe; row/col 3-r == ~r.
  assign w_pos = key_pos(r_key);

  always_comb begin
    w_row_drv = 4'hF;
    w_row_drv[~w_pos[3:2]] = col_n[~w_pos[1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst)                       r_row_n <= 4'hF;
    else if (r_state == ST_PRESS)  r_row_n <= w_row_drv;
    else                           r_row_n <= 4'hF;
  end

  assign row_n      = r_row_n;
  assign key_active = r_key_active;
  assign key_done   = r_key_done;
  assign busy       = (r_state != ST_IDLE) || !w_q_empty;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: accepted keys are queued as expectations and a
// cycle monitor checks row drive, press/gap timing, key_done, busy and cmd_ready.
module tb_keypad_emulator;

  localparam int HOLD  = 4;
  localparam int GAP   = 3;
  localparam int DEPTH = 4;
`ifdef KEYPAD_EMU_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int PH_IDLE  = 0;
  localparam int PH_PRESS = 1;
  localparam int PH_GAP   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n = 4'hF;
  logic [3:0] row_n;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_key = 4'h0;
  logic       cmd_ready;
  logic       key_active;
  logic       key_done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q [$];
  bit         scan_zero = 1'b0;
  bit         scan_rand = 1'b0;

  // Physical layout, row-major: index = row*4 + col.
  logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};
  logic [3:0] scan_seq [4] = '{4'h7, 4'hB, 4'hD, 4'hE};

  keypad_emulator #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .cmd_valid (cmd_valid),
    .cmd_key   (cmd_key),
    .cmd_ready (cmd_ready),
    .key_active(key_active),
    .key_done  (key_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] model_row(input logic [3:0] key, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 16; i++)
      if (layout[i] == key) r[3 - i / 4] = cols[3 - i % 4];
    return r;
  endfunction

  // Scanner: strobes one column low per cycle, changing on the falling edge.
  initial begin : scanner
    int idx;
    idx = 0;
    forever begin
      @(negedge clk);
      if (scan_zero)      col_n = 4'h0;
      else if (scan_rand) col_n = 4'($urandom);
      else                col_n = scan_seq[idx];
      idx = (idx + 1) % 4;
    end
  end

  // Monitor: reference timeline of each command, checked once per cycle.
  initial begin : monitor
    int         ph;
    int         n;
    int         prev_pending;
    bit         prev_press;
    logic [3:0] cur_key;
    logic [3:0] exp_row;
    ph = PH_IDLE; n = 0; prev_pending = 0; prev_press = 1'b0; cur_key = 4'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        exp_q.delete();
        ph = PH_IDLE; n = 0; prev_pending = 0; prev_press = 1'b0;
        chk("reset_row_n",      32'(row_n), 32'hF);
        chk("reset_key_active", 32'(key_active), 32'd0);
        chk("reset_key_done",   32'(key_done), 32'd0);
        chk("reset_busy",       32'(busy), 32'd0);
        chk("reset_cmd_ready",  32'(cmd_ready), 32'd1);
      end else begin
        exp_row = prev_press ? model_row(cur_key, col_n) : 4'hF;
        chk("row_n", 32'(row_n), 32'(exp_row));
        case (ph)
          PH_IDLE: begin
            if (prev_pending > 0) begin
              cur_key = exp_q.pop_front();
              ph = PH_PRESS; n = 1;
            end
          end
          PH_PRESS: begin
            if (n < HOLD) n++;
            else begin ph = PH_GAP; n = 1; end
          end
          default: begin
            if (n < GAP) n++;
            else begin ph = PH_IDLE; n = 0; end
          end
        endcase
        chk("key_active", 32'(key_active), 32'(ph == PH_PRESS));
        chk("key_done",   32'(key_done),   32'(ph == PH_GAP && n == GAP));
        chk("busy",       32'(busy),       32'(ph != PH_IDLE || exp_q.size() != 0));
        chk("cmd_ready",  32'(cmd_ready),
            32'(FIFO_EN ? (exp_q.size() < DEPTH) : (exp_q.size() == 0)));
        prev_press   = (ph == PH_PRESS);
        prev_pending = exp_q.size();
      end
    end
  end

  // Offers one key and holds it until accepted; the accepted key enters the scoreboard.
  task automatic send(input logic [3:0] k);
    int t;
    bit ok;
    t = 0; ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_key   = k;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      if (ok) exp_q.push_back(k);
      t++;
    end
    #2;
    cmd_valid = 1'b0;
    cmd_key   = 4'($urandom);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0 || key_active) && t < 2000) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 2000) chk("wait_idle_timeout", 32'd0, 32'd1);
    idle_cycles(2);
  endtask

  task automatic wait_press();
    int t;
    t = 0;
    while (!key_active && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 200) chk("wait_press_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle_cycles(2);

    // single key
    send(4'h5);
    wait_idle();

    // back-to-back keys
    send(4'h1);
    send(4'hD);
    send(4'hA);
    wait_idle();

    // more keys than the buffer holds: later ones stall on cmd_ready
    if (FIFO_EN) begin
      for (int i = 0; i < DEPTH + 2; i++) send(4'(i + 3));
    end else begin
      send(4'h2);
      send(4'h7);
      send(4'hC);
    end
    wait_idle();

    // reset in the middle of a press, with another key still queued
    send(4'h9);
    send(4'h4);
    wait_press();
    idle_cycles(1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    idle_cycles(4);
    wait_idle();

    // every column strobed at once: only the latched key's row responds
    scan_zero = 1'b1;
    send(4'hE);
    send(4'h0);
    wait_idle();
    scan_zero = 1'b0;

    // every key code once, then random keys with random spacing and column noise
    for (int k = 0; k < 16; k++) send(4'(k));
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      scan_rand = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 12));
      send(4'($urandom_range(0, 15)));
    end
    wait_idle();
    scan_rand = 1'b0;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
